// File: rtl/fir_coeff_packer.sv
`default_nettype none
// ============================================================================
// Module   : fir_coeff_packer
// Purpose  : Collects NB_TAPS narrow coefficients, one per stream handshake,
//            into a single wide vector and presents it on the h stream that
//            feeds fir_datapath. Coefficient k of a vector lands in lane k.
// Revision : 1.0 - initial release
// ============================================================================
module fir_coeff_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int NB_TAPS    = 50,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             clear_i,
  input  logic                             enable_i,
  // narrow coefficient sink stream
  input  logic [DATA_WIDTH-1:0]            coeff_data_i,
  input  logic [DATA_WIDTH/8-1:0]          coeff_strb_i,
  input  logic                             coeff_valid_i,
  output logic                             coeff_ready_o,
  // packed coefficient source stream
  output logic [DATA_WIDTH*NB_TAPS-1:0]    h_data_o,
  output logic [DATA_WIDTH*NB_TAPS/8-1:0]  h_strb_o,
  output logic                             h_valid_o,
  input  logic                             h_ready_i,
  // status
  output logic                             busy_o,
  output logic [CNT_WIDTH-1:0]             nb_vectors_o
);

  localparam int c_STRB_W = DATA_WIDTH / 8;
  localparam int c_CNT_W  = (NB_TAPS > 1) ? $clog2(NB_TAPS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST_SLOT = c_CNT_W'(NB_TAPS - 1);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_h_valid;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_nb_vectors;

  logic                 w_coeff_ready;
  logic                 w_accept;

  // While FULL, a new coefficient may enter only if the held vector leaves
  // in the same cycle, hence the combinational path from h_ready_i.
  assign w_coeff_ready = enable_i & ~clear_i & ((r_state == ST_FILL) | h_ready_i);
  assign w_accept      = coeff_valid_i & w_coeff_ready;

  assign coeff_ready_o = w_coeff_ready;
  assign h_valid_o     = r_h_valid;
  assign busy_o        = r_busy;
  assign nb_vectors_o  = r_nb_vectors;

  // Control FSM: slot counter, output valid, busy flag and vector counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= ST_FILL;
      r_cnt        <= '0;
      r_h_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_nb_vectors <= '0;
    end else if (clear_i) begin
      // Soft clear discards any partial or pending vector, even one that
      // would have handshaken this cycle.
      r_state      <= ST_FILL;
      r_cnt        <= '0;
      r_h_valid    <= 1'b0;
      r_busy       <= 1'b0;
      r_nb_vectors <= '0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_busy <= 1'b1;
            if (r_cnt == c_LAST_SLOT) begin
              r_cnt     <= '0;
              r_state   <= ST_FULL;
              r_h_valid <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_FULL: begin
          // Valid is held until the consumer takes the vector, regardless
          // of enable_i.
          if (h_ready_i) begin
            r_nb_vectors <= r_nb_vectors + 1'b1;
            r_state      <= ST_FILL;
            r_h_valid    <= 1'b0;
            if (w_accept) begin
              r_cnt  <= c_CNT_W'(1);
              r_busy <= 1'b1;
            end else begin
              r_cnt  <= '0;
              r_busy <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_FILL;
          r_cnt     <= '0;
          r_h_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // One storage lane per tap. r_cnt is zero whenever the FSM is FULL, so a
  // coefficient taken during the output handshake lands in lane 0. Lanes of
  // an earlier vector are left in place; h_valid_o low masks them.
  for (genvar k = 0; k < NB_TAPS; k++) begin : g_slot
    logic [DATA_WIDTH-1:0] r_slot_data;
    logic [c_STRB_W-1:0]   r_slot_strb;
    logic                  w_slot_we;

    assign w_slot_we = w_accept & (r_cnt == c_CNT_W'(k));

    // Capture the coefficient addressed to this lane.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_slot_data <= '0;
        r_slot_strb <= '0;
      end else if (clear_i) begin
        r_slot_data <= '0;
        r_slot_strb <= '0;
      end else if (w_slot_we) begin
        r_slot_data <= coeff_data_i;
        r_slot_strb <= coeff_strb_i;
      end
    end

    assign h_data_o[k*DATA_WIDTH +: DATA_WIDTH] = r_slot_data;
    assign h_strb_o[k*c_STRB_W   +: c_STRB_W]   = r_slot_strb;
  end

endmodule
`default_nettype wire

// File: tb/tb_fir_coeff_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_coeff_packer
// Purpose  : Directed self-checking bench for fir_coeff_packer with
//            DATA_WIDTH=16, NB_TAPS=4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_coeff_packer;

  localparam int c_DW  = 16;
  localparam int c_NB  = 4;
  localparam int c_CW  = 16;

  logic                  clk_i = 1'b0;
  logic                  rst_ni;
  logic                  clear_i;
  logic                  enable_i;
  logic [c_DW-1:0]       coeff_data_i;
  logic [c_DW/8-1:0]     coeff_strb_i;
  logic                  coeff_valid_i;
  logic                  coeff_ready_o;
  logic [c_DW*c_NB-1:0]  h_data_o;
  logic [c_DW*c_NB/8-1:0] h_strb_o;
  logic                  h_valid_o;
  logic                  h_ready_i;
  logic                  busy_o;
  logic [c_CW-1:0]       nb_vectors_o;

  int n_vec = 0;
  int n_err = 0;

  fir_coeff_packer #(
    .DATA_WIDTH (c_DW),
    .NB_TAPS    (c_NB),
    .CNT_WIDTH  (c_CW)
  ) u_dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .enable_i      (enable_i),
    .coeff_data_i  (coeff_data_i),
    .coeff_strb_i  (coeff_strb_i),
    .coeff_valid_i (coeff_valid_i),
    .coeff_ready_o (coeff_ready_o),
    .h_data_o      (h_data_o),
    .h_strb_o      (h_strb_o),
    .h_valid_o     (h_valid_o),
    .h_ready_i     (h_ready_i),
    .busy_o        (busy_o),
    .nb_vectors_o  (nb_vectors_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack4(input logic [15:0] c0, input logic [15:0] c1,
                                         input logic [15:0] c2, input logic [15:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  // advance to 1 time unit after the next rising edge
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // present one coefficient for one clock edge
  task automatic push(input logic [15:0] d);
    coeff_valid_i = 1'b1;
    coeff_data_i  = d;
    cyc();
  endtask

  initial begin
    rst_ni        = 1'b0;
    clear_i       = 1'b0;
    enable_i      = 1'b1;
    coeff_data_i  = '0;
    coeff_strb_i  = 2'b11;
    coeff_valid_i = 1'b0;
    h_ready_i     = 1'b1;

    // ---------------- reset state ----------------
    #1;
    chk("rst_h_valid", 64'(h_valid_o), 64'd0);
    chk("rst_busy",    64'(busy_o), 64'd0);
    chk("rst_nb",      64'(nb_vectors_o), 64'd0);
    chk("rst_h_data",  h_data_o, 64'd0);
    chk("rst_h_strb",  64'(h_strb_o), 64'd0);
    chk("rst_c_ready", 64'(coeff_ready_o), 64'd1);
    #11;
    rst_ni = 1'b1;
    cyc();

    // ---------------- 1. basic pack ----------------
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    push(16'h0004);
    coeff_valid_i = 1'b0;
    chk("t1_h_valid", 64'(h_valid_o), 64'd1);
    chk("t1_h_data",  h_data_o, 64'h0004_0003_0002_0001);
    chk("t1_h_strb",  64'(h_strb_o), 64'hFF);
    chk("t1_busy_full", 64'(busy_o), 64'd1);
    cyc();
    chk("t1_nb",      64'(nb_vectors_o), 64'd1);
    chk("t1_busy",    64'(busy_o), 64'd0);
    chk("t1_h_valid_lo", 64'(h_valid_o), 64'd0);

    // ---------------- 2. backpressure ----------------
    h_ready_i = 1'b0;
    push(16'h0005);
    push(16'h0006);
    push(16'h0007);
    push(16'h0008);
    coeff_data_i  = 16'h0011;
    coeff_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_hold_valid", 64'(h_valid_o), 64'd1);
      chk("t2_hold_data",  h_data_o, 64'h0008_0007_0006_0005);
      chk("t2_hold_ready", 64'(coeff_ready_o), 64'd0);
      cyc();
    end
    chk("t2_nb_held", 64'(nb_vectors_o), 64'd1);
    h_ready_i = 1'b1;
    #1;
    chk("t2_c_ready_pass", 64'(coeff_ready_o), 64'd1);
    cyc();
    chk("t2_nb",       64'(nb_vectors_o), 64'd2);
    chk("t2_valid_lo", 64'(h_valid_o), 64'd0);
    chk("t2_busy_cnt1", 64'(busy_o), 64'd1);
    push(16'h0012);
    push(16'h0013);
    push(16'h0014);
    coeff_valid_i = 1'b0;
    chk("t2_vec_valid", 64'(h_valid_o), 64'd1);
    chk("t2_vec_data",  h_data_o, 64'h0014_0013_0012_0011);
    cyc();
    chk("t2_nb_final", 64'(nb_vectors_o), 64'd3);

    // ---------------- 3. back-to-back ----------------
    for (int i = 1; i <= 12; i++) begin
      coeff_valid_i = 1'b1;
      coeff_data_i  = 16'(i);
      #1;
      chk("t3_c_ready", 64'(coeff_ready_o), 64'd1);
      cyc();
      if (i % 4 == 0) begin
        chk("t3_vec_valid", 64'(h_valid_o), 64'd1);
        chk("t3_vec_data", h_data_o,
            pack4(16'(i - 3), 16'(i - 2), 16'(i - 1), 16'(i)));
      end
    end
    coeff_valid_i = 1'b0;
    cyc();
    chk("t3_nb", 64'(nb_vectors_o), 64'd6);
    chk("t3_busy", 64'(busy_o), 64'd0);

    // ---------------- 4. clear mid-fill ----------------
    push(16'hAAAA);
    push(16'hBBBB);
    coeff_valid_i = 1'b0;
    chk("t4_busy_partial", 64'(busy_o), 64'd1);
    clear_i = 1'b1;
    #1;
    chk("t4_c_ready_clr", 64'(coeff_ready_o), 64'd0);
    cyc();
    clear_i = 1'b0;
    chk("t4_busy_clr", 64'(busy_o), 64'd0);
    chk("t4_nb_clr",   64'(nb_vectors_o), 64'd0);
    chk("t4_data_clr", h_data_o, 64'd0);
    push(16'h0001);
    push(16'h0002);
    push(16'h0003);
    push(16'h0004);
    coeff_valid_i = 1'b0;
    chk("t4_vec_data", h_data_o, 64'h0004_0003_0002_0001);
    cyc();
    chk("t4_nb", 64'(nb_vectors_o), 64'd1);
    // clear during a pending handshake with a simultaneous offered coefficient
    h_ready_i = 1'b0;
    push(16'h0009);
    push(16'h000A);
    push(16'h000B);
    push(16'h000C);
    chk("t4b_full", 64'(h_valid_o), 64'd1);
    h_ready_i     = 1'b1;
    clear_i       = 1'b1;
    coeff_valid_i = 1'b1;
    coeff_data_i  = 16'h0055;
    cyc();
    clear_i       = 1'b0;
    coeff_valid_i = 1'b0;
    chk("t4b_valid", 64'(h_valid_o), 64'd0);
    chk("t4b_nb",    64'(nb_vectors_o), 64'd0);
    chk("t4b_busy",  64'(busy_o), 64'd0);
    chk("t4b_data",  h_data_o, 64'd0);

    // ---------------- 5. enable low ----------------
    push(16'h0021);
    push(16'h0022);
    enable_i      = 1'b0;
    coeff_data_i  = 16'h0023;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_c_ready", 64'(coeff_ready_o), 64'd0);
      chk("t5_busy",    64'(busy_o), 64'd1);
      chk("t5_valid",   64'(h_valid_o), 64'd0);
      cyc();
    end
    enable_i = 1'b1;
    push(16'h0023);
    push(16'h0024);
    coeff_valid_i = 1'b0;
    chk("t5_vec_valid", 64'(h_valid_o), 64'd1);
    chk("t5_vec_data",  h_data_o, 64'h0024_0023_0022_0021);
    cyc();
    chk("t5_nb", 64'(nb_vectors_o), 64'd1);

    // ---------------- 6. async reset in FULL ----------------
    h_ready_i = 1'b0;
    push(16'h0031);
    push(16'h0032);
    push(16'h0033);
    push(16'h0034);
    coeff_valid_i = 1'b0;
    chk("t6_full", 64'(h_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(h_valid_o), 64'd0);
    chk("t6_rst_nb",    64'(nb_vectors_o), 64'd0);
    chk("t6_rst_busy",  64'(busy_o), 64'd0);
    chk("t6_rst_data",  h_data_o, 64'd0);
    #1;
    rst_ni    = 1'b1;
    h_ready_i = 1'b1;
    cyc();
    push(16'h0041);
    push(16'h0042);
    push(16'h0043);
    push(16'h0044);
    coeff_valid_i = 1'b0;
    chk("t6_vec_data", h_data_o, 64'h0044_0043_0042_0041);
    cyc();
    chk("t6_nb", 64'(nb_vectors_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_coeff_packer.md
Name: fir_coeff_packer

Overview:
Producer side of the FIR coefficient interface. Accepts coefficients one per handshake on a narrow HWPE-Stream of DATA_WIDTH bits. Packs NB_TAPS of them into one wide vector and emits it on a DATA_WIDTH*NB_TAPS HWPE-Stream, the h stream consumed by fir_datapath. Sits between the coefficient source streamer and fir_datapath.

Parameters:
DATA_WIDTH, 16, width of one coefficient.
NB_TAPS, 50, coefficients per packed vector; must be >= 2.
CNT_WIDTH, 16, width of the emitted-vector counter.

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_ni  input  1  reset, asynchronous, active-low.
clear_i  input  1  synchronous soft clear.
enable_i  input  1  local enable; gates coefficient acceptance.
coeff  hwpe_stream_intf_stream.sink  DATA_WIDTH  narrow coefficient input stream (data/strb/valid/ready).
h  hwpe_stream_intf_stream.source  DATA_WIDTH*NB_TAPS  packed coefficient output stream.
busy_o  output  1  high while a partial vector is held or h.valid is high.
nb_vectors_o  output  CNT_WIDTH  number of completed h handshakes, wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (rst_ni low, async): FSM=FILL, tap counter=0, packed data/strb=0, h.valid=0, busy_o=0, nb_vectors_o=0. coeff.ready follows its combinational rule (1 once enable_i=1).
- FSM states:
  - FILL: collecting coefficients, h.valid=0.
  - FULL: vector complete, h.valid=1.
- Packing order: the k-th accepted coefficient (k=0..NB_TAPS-1) goes to h.data[k*DATA_WIDTH +: DATA_WIDTH]. Its strb goes to h.strb[k*DATA_WIDTH/8 +: DATA_WIDTH/8].
- coeff.ready = enable_i & ~clear_i & ((state==FILL) | h.ready). Combinational path from h.ready to coeff.ready is intended.
- Accept condition: coeff.valid & coeff.ready.
- FILL + accept:
  - write slot cnt.
  - If cnt==NB_TAPS-1: cnt<=0, state<=FULL (h.valid high next cycle; one cycle latency from last coefficient to valid).
  - Else cnt<=cnt+1.
- FULL:
  - h.data/h.strb/h.valid held stable until h.ready. Valid is never dropped without handshake, even if enable_i falls.
  - On h handshake: nb_vectors_o<=nb_vectors_o+1.
  - If no accept in the same cycle: state<=FILL.
  - If a coefficient is accepted in the same cycle (only possible when h.ready=1): it is written to slot 0, cnt<=1, state<=FILL. Back-to-back vectors need no bubble on coeff.
- Slot reuse: slots 1..NB_TAPS-1 of a previous vector are not cleared on handshake; h.valid=0 masks them.
- enable_i low: no acceptance, counter frozen; FULL still completes its handshake.
- clear_i high (sync):
  - cnt<=0, state<=FILL, h.valid<=0, data/strb<=0; nb_vectors_o<=0.
  - Any partial vector is discarded. Overrides simultaneous accept and h handshake in the same cycle (handshake not counted).
- busy_o = (state==FULL) | (cnt!=0).
- A reset mid-fill or mid-FULL drops all state immediately. No partial vector survives.

Test Plan:
(Bench override: DATA_WIDTH=16, NB_TAPS=4, h.ready=1 unless stated.)
1. Basic pack: push 0x0001,0x0002,0x0003,0x0004 on consecutive cycles -> one cycle after 4th accept h.valid=1, h.data=0x0004_0003_0002_0001, h.strb=0xFF; after handshake nb_vectors_o=1, busy_o=0.
2. Backpressure: hold h.ready=0 for 10 cycles after vector 1 -> h.data stable and h.valid=1 throughout, coeff.ready=0; when h.ready=1 and coeff.valid=1 with 0x0011, handshake and slot-0 write occur in the same cycle, cnt=1.
3. Back-to-back: stream 12 coefficients 1..12 with continuous valid and ready -> three vectors 0x0004_0003_0002_0001, 0x0008_..._0005, 0x000C_..._0009; coeff.ready never drops; nb_vectors_o=3.
4. Clear mid-fill: push 0xAAAA,0xBBBB, assert clear_i one cycle, then push 1,2,3,4 -> emitted vector 0x0004_0003_0002_0001; no trace of 0xAAAA/0xBBBB.
5. enable_i low: drop enable_i after 2 of 4 coefficients for 5 cycles while coeff.valid=1 -> coeff.ready=0, cnt held at 2; on re-enable, vector completes with correct ordering.
6. Async reset in FULL with h.ready=0: pulse rst_ni low mid-cycle -> h.valid=0 immediately, nb_vectors_o=0, busy_o=0; next 4 coefficients form a fresh vector.
